itof_arbiter: RTL and testbench
===============================

ITOF_ARBITER -- requirements
Module: itof_arbiter

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, width of the grant counter.
REQ-002 The block SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have ports req0/req1  input  1  requester 0/1 conversion request, held until granted.
REQ-005 The block SHALL have ports int0/int1  input  32  requester 0/1 signed two's-complement operand, stable while req is high.
REQ-006 The block SHALL have ports gnt0/gnt1  output  1  combinational grant, same cycle as the winning req.
REQ-007 The block SHALL have port fp_out  output  32  IEEE-754 single result, shared by both requesters.
REQ-008 The block SHALL have ports fp_vld0/fp_vld1  output  1  one-cycle pulse: fp_out belongs to requester 0/1.
REQ-009 The block SHALL have port grant_cnt  output  CNT_W  total grants issued since reset.

Function
REQ-010 The block SHALL contain exactly one signed-int-to-float conversion datapath, shared between both requesters.
REQ-011 Grant rule: gnt_i = req_i AND requester i wins; at most one gnt per cycle; gnt never asserts without req.
REQ-012 Arbitration: single req wins; if both request, the requester not granted most recently wins (round-robin).
REQ-013 Round-robin pointer `last` SHALL update to the granted id on every grant cycle; unchanged in no-grant cycles.
REQ-014 Stage 1: at the edge ending grant cycle N, register the granted operand, requester id and valid bit.
REQ-015 Stage 2: conversion is combinational on the stage-1 register; at the edge ending cycle N+1, register the result into fp_out and the id/valid into the output stage.
REQ-016 Latency SHALL be exactly 2 cycles: grant in cycle N -> fp_vld_id high in cycle N+2 only.
REQ-017 Throughput SHALL be one conversion per cycle; back-to-back grants SHALL produce back-to-back fp_vld pulses in grant order.
REQ-018 No backpressure: results are never stalled or dropped; requesters SHALL sample fp_out when their fp_vld is high.
REQ-019 fp_out SHALL hold its last value when no result is valid; fp_vld0 and fp_vld1 SHALL never both be high.
REQ-020 Conversion: sign = operand[31]; magnitude normalized; exponent = 127 + index of the leading one; the mantissa holds the 23 bits below the leading one.
REQ-021 Mantissa bits below those 23 SHALL be truncated; no rounding.
REQ-022 Operand 0 SHALL yield 0x00000000; no negative zero is produced.
REQ-023 Operand 0x80000000 SHALL yield 0xCF000000; this case is detected explicitly, because the 31-bit magnitude path overflows.
REQ-024 grant_cnt SHALL increment by 1 per grant and wrap from all-ones to 0.

Reset
REQ-025 While rst_n is low, independent of clk, the following SHALL be cleared: all pipeline valids, fp_out = 0, fp_vld0/1 = 0, grant_cnt = 0, last = 1 (requester 0 wins the first contention).
REQ-026 gnt0/gnt1 SHALL be 0 while rst_n is low, regardless of req.
REQ-027 Reset mid-operation: grants issued before reset SHALL produce no fp_vld pulse after rst_n deasserts.
REQ-028 First grant is possible in the first cycle after rst_n deasserts.

Verification
REQ-029 Reset release; req0=1, int0=1 in cycle 0 -> gnt0=1 in cycle 0; fp_vld0=1 with fp_out=0x3F800000 in cycle 2; grant_cnt=1.
REQ-030 req0 and req1 held high for 4 cycles, int0=100, int1=-1 -> gnts 0,1,0,1; results 0x42C80000, 0xBF800000 alternating with fp_vld0/fp_vld1, cycles 2..5.
REQ-031 Boundary operands via req1: 0 -> 0x00000000; 0x7FFFFFFF -> 0x4EFFFFFF; 0x80000000 -> 0xCF000000; 0x01000001 -> 0x4B800000 (truncation).
REQ-032 Grant in cycle N, rst_n pulsed low in cycle N+1 -> no fp_vld in cycles N+1..N+4; fp_out=0, grant_cnt=0, next contention won by requester 0.
REQ-033 CNT_W=4, 17 consecutive req0 grants -> grant_cnt reads 0xF after 15 grants, 0x0 after 16, 0x1 after 17.
REQ-034 Random req/int stream against a reference model -> every grant yields exactly one fp_vld to the correct requester, in order, 2 cycles later, with a bit-exact result.

Source files
------------

// File: rtl/itof_arbiter.sv
// rtl/itof_arbiter.sv - two-requester round-robin arbiter in front of one shared int-to-float converter
// A grant in cycle N produces the matching fp_vld pulse and fp_out in cycle N+2.
module itof_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [31:0]      int0,
    input  logic [31:0]      int1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [31:0]      fp_out,
    output logic             fp_vld0,
    output logic             fp_vld1,
    output logic [CNT_W-1:0] grant_cnt
);

    logic             last_q, last_d;
    logic             s1_vld_q, s1_vld_d;
    logic             s1_id_q, s1_id_d;
    logic [31:0]      s1_op_q, s1_op_d;
    logic [31:0]      fp_q, fp_d;
    logic             vld0_q, vld0_d;
    logic             vld1_q, vld1_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             win0, win1;
    logic             cv_sign;
    logic [30:0]      cv_mag;
    logic [4:0]       cv_lead;
    logic [30:0]      cv_norm;
    logic [31:0]      conv;

    // last_q == 1 means requester 1 was granted most recently, so requester 0 wins a tie
    always_comb begin
        win0 = req0 & (~req1 | last_q);
        win1 = req1 & (~req0 | ~last_q);
    end

    assign gnt0 = rst_n & win0;
    assign gnt1 = rst_n & win1;

    // Converter on the stage-1 operand; the most negative value is special-cased
    // because its magnitude does not fit the 31-bit path.
    always_comb begin
        cv_sign = s1_op_q[31];
        cv_mag  = s1_op_q[31] ? 31'(-s1_op_q) : s1_op_q[30:0];
        cv_lead = '0;
        for (int i = 0; i < 31; i++) begin
            if (cv_mag[i]) begin
                cv_lead = 5'(i);
            end
        end
        cv_norm = cv_mag << (5'd30 - cv_lead);
        if (s1_op_q == 32'h0000_0000) begin
            conv = 32'h0000_0000;
        end else if (s1_op_q == 32'h8000_0000) begin
            conv = 32'hCF00_0000;
        end else begin
            conv = {cv_sign, 8'd127 + {3'b000, cv_lead}, cv_norm[29:7]};
        end
    end

    always_comb begin
        last_d   = last_q;
        cnt_d    = cnt_q;
        s1_vld_d = gnt0 | gnt1;
        s1_id_d  = gnt1;
        s1_op_d  = gnt1 ? int1 : int0;
        fp_d     = fp_q;
        vld0_d   = s1_vld_q & ~s1_id_q;
        vld1_d   = s1_vld_q & s1_id_q;
        if (gnt0 | gnt1) begin
            last_d = gnt1;
            cnt_d  = cnt_q + CNT_W'(1);
        end
        if (s1_vld_q) begin
            fp_d = conv;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q   <= 1'b1;
            cnt_q    <= '0;
            s1_vld_q <= 1'b0;
            s1_id_q  <= 1'b0;
            s1_op_q  <= '0;
            fp_q     <= '0;
            vld0_q   <= 1'b0;
            vld1_q   <= 1'b0;
        end else begin
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            s1_vld_q <= s1_vld_d;
            s1_id_q  <= s1_id_d;
            s1_op_q  <= s1_op_d;
            fp_q     <= fp_d;
            vld0_q   <= vld0_d;
            vld1_q   <= vld1_d;
        end
    end

    assign fp_out    = fp_q;
    assign fp_vld0   = vld0_q;
    assign fp_vld1   = vld1_q;
    assign grant_cnt = cnt_q;

endmodule

// File: tb/tb_itof_arbiter.sv
// tb/tb_itof_arbiter.sv - self-checking bench for itof_arbiter
// Directed scenarios plus a random stream checked against a timestamped result queue.
module tb_itof_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [31:0] int0 = '0, int1 = '0;
    logic        gnt0, gnt1, fp_vld0, fp_vld1;
    logic [31:0] fp_out;
    logic [15:0] grant_cnt;

    logic        w_req0 = 1'b0, w_req1 = 1'b0;
    logic [31:0] w_int0 = '0, w_int1 = '0;
    logic        w_gnt0, w_gnt1, w_vld0, w_vld1;
    logic [31:0] w_fp;
    logic [3:0]  w_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    itof_arbiter u_dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .int0(int0), .int1(int1),
        .gnt0(gnt0), .gnt1(gnt1), .fp_out(fp_out), .fp_vld0(fp_vld0), .fp_vld1(fp_vld1),
        .grant_cnt(grant_cnt)
    );

    itof_arbiter #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .req0(w_req0), .req1(w_req1), .int0(w_int0), .int1(w_int1),
        .gnt0(w_gnt0), .gnt1(w_gnt1), .fp_out(w_fp), .fp_vld0(w_vld0), .fp_vld1(w_vld1),
        .grant_cnt(w_cnt)
    );

    function automatic logic [31:0] fp_ref(input logic [31:0] x);
        longint m;
        longint mant;
        int     e;
        logic   s;
        logic [7:0] ex;
        if (x == 32'h0) return 32'h0;
        s = x[31];
        m = longint'($signed(x));
        if (m < 0) m = -m;
        e = 0;
        while ((m >> (e + 1)) != 0) e++;
        mant = ((m - (64'sd1 << e)) << 23) >> e;
        ex = 8'(127 + e);
        return {s, ex, mant[22:0]};
    endfunction

    // Reference: each grant schedules its result for two cycles later
    typedef struct { int due; bit id; logic [31:0] val; } res_t;
    res_t        m_q[$];
    bit          m_last = 1'b1;
    logic [15:0] m_cnt = '0;
    logic [31:0] m_hold = '0;
    bit          m_v0 = 1'b0, m_v1 = 1'b0;
    int          cyc = 0;

    initial begin : model
        bit g0, g1;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_last = 1'b1; m_cnt = '0; m_hold = '0; m_v0 = 1'b0; m_v1 = 1'b0;
                cyc = 0; m_q.delete();
            end else begin
                g0 = req0 && (!req1 || m_last);
                g1 = req1 && (!req0 || !m_last);
                if (m_q.size() != 0 && m_q[0].due == cyc) void'(m_q.pop_front());
                if (g0 || g1) begin
                    m_q.push_back('{cyc + 2, g1, fp_ref(g1 ? int1 : int0)});
                    m_last = g1;
                    m_cnt++;
                end
                cyc++;
                m_v0 = 1'b0; m_v1 = 1'b0;
                if (m_q.size() != 0 && m_q[0].due == cyc) begin
                    m_hold = m_q[0].val;
                    m_v0 = !m_q[0].id;
                    m_v1 = m_q[0].id;
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; w_req0 = 1'b0; w_req1 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 6))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'h7FFF_FFFF;
            3: return 32'($urandom_range(0, 255));
            4: return -32'($urandom_range(1, 255));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        #1;
        rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1; int0 = 32'd7; int1 = 32'd9;
        #1;
        checks += 5;
        if (gnt0 !== 1'b0) begin errors++; $display("FAIL reset_gnt0: got %b expected 0", gnt0); end
        if (gnt1 !== 1'b0) begin errors++; $display("FAIL reset_gnt1: got %b expected 0", gnt1); end
        if (fp_out !== 32'h0) begin errors++; $display("FAIL reset_fp_out: got %h expected 00000000", fp_out); end
        if ({fp_vld0, fp_vld1} !== 2'b00) begin errors++; $display("FAIL reset_vld: got %b expected 00", {fp_vld0, fp_vld1}); end
        if (grant_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt: got %h expected 0000", grant_cnt); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks += 2;
        if ({gnt0, gnt1} !== 2'b00) begin errors++; $display("FAIL reset_gnt_clocked: got %b expected 00", {gnt0, gnt1}); end
        if ({fp_vld0, fp_vld1} !== 2'b00) begin errors++; $display("FAIL reset_vld_clocked: got %b expected 00", {fp_vld0, fp_vld1}); end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_single();
        @(posedge clk); #1;
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; req0 = 1'b1; int0 = 32'd1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin @(posedge clk); #1; req0 = 1'b0; end
            @(negedge clk);
            if (k == 0) begin
                checks += 2;
                if (gnt0 !== 1'b1) begin errors++; $display("FAIL single_gnt0: got %b expected 1", gnt0); end
                if (gnt1 !== 1'b0) begin errors++; $display("FAIL single_gnt1: got %b expected 0", gnt1); end
            end
            checks += 3;
            if (fp_vld0 !== (k == 2)) begin errors++; $display("FAIL single_vld0 c%0d: got %b expected %b", k, fp_vld0, k == 2); end
            if (fp_vld1 !== 1'b0) begin errors++; $display("FAIL single_vld1 c%0d: got %b expected 0", k, fp_vld1); end
            if (grant_cnt !== 16'(k > 0)) begin errors++; $display("FAIL single_cnt c%0d: got %0d expected %0d", k, grant_cnt, k > 0); end
            if (k >= 2) begin
                checks++;
                if (fp_out !== 32'h3F80_0000) begin errors++; $display("FAIL single_fp c%0d: got %h expected 3f800000", k, fp_out); end
            end
        end
    endtask

    task automatic test_contention();
        logic [31:0] exp_fp;
        bit id;
        do_reset();
        int0 = 32'd100; int1 = 32'hFFFF_FFFF;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            req0 = (k < 4); req1 = (k < 4);
            @(negedge clk);
            checks += 4;
            if (gnt0 !== (k < 4 && k % 2 == 0)) begin errors++; $display("FAIL rr_gnt0 c%0d: got %b", k, gnt0); end
            if (gnt1 !== (k < 4 && k % 2 == 1)) begin errors++; $display("FAIL rr_gnt1 c%0d: got %b", k, gnt1); end
            id = (k >= 2) && ((k - 2) % 2 == 1);
            exp_fp = id ? 32'hBF80_0000 : 32'h42C8_0000;
            if (fp_vld0 !== (k >= 2 && !id)) begin errors++; $display("FAIL rr_vld0 c%0d: got %b", k, fp_vld0); end
            if (fp_vld1 !== (k >= 2 && id)) begin errors++; $display("FAIL rr_vld1 c%0d: got %b", k, fp_vld1); end
            if (k >= 2) begin
                checks++;
                if (fp_out !== exp_fp) begin errors++; $display("FAIL rr_fp c%0d: got %h expected %h", k, fp_out, exp_fp); end
            end
        end
    endtask

    task automatic test_boundary();
        logic [31:0] ops  [5] = '{32'h0000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0100_0001, 32'hFFFF_FF9C};
        logic [31:0] exps [5] = '{32'h0000_0000, 32'h4EFF_FFFF, 32'hCF00_0000, 32'h4B80_0000, 32'hC2C8_0000};
        do_reset();
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            req1 = (k < 5);
            if (k < 5) int1 = ops[k];
            @(negedge clk);
            if (k < 5) begin
                checks++;
                if (gnt1 !== 1'b1) begin errors++; $display("FAIL bnd_gnt1 c%0d: got %b expected 1", k, gnt1); end
            end
            if (k >= 2) begin
                checks += 2;
                if ({fp_vld0, fp_vld1} !== 2'b01) begin errors++; $display("FAIL bnd_vld c%0d: got %b expected 01", k, {fp_vld0, fp_vld1}); end
                if (fp_out !== exps[k-2]) begin errors++; $display("FAIL bnd_fp op=%h: got %h expected %h", ops[k-2], fp_out, exps[k-2]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(posedge clk); #1;
        req0 = 1'b1; int0 = 32'd5;
        @(negedge clk);
        checks++;
        if (gnt0 !== 1'b1) begin errors++; $display("FAIL mid_gnt0: got %b expected 1", gnt0); end
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            req0 = 1'b0;
            rst_n = (k != 1);
            @(negedge clk);
            checks++;
            if ({fp_vld0, fp_vld1} !== 2'b00) begin errors++; $display("FAIL mid_vld N+%0d: got %b expected 00", k, {fp_vld0, fp_vld1}); end
        end
        checks += 2;
        if (fp_out !== 32'h0) begin errors++; $display("FAIL mid_fp: got %h expected 00000000", fp_out); end
        if (grant_cnt !== 16'h0) begin errors++; $display("FAIL mid_cnt: got %0d expected 0", grant_cnt); end
        @(posedge clk); #1;
        req0 = 1'b1; req1 = 1'b1; int0 = 32'd3; int1 = 32'd4;
        @(negedge clk);
        checks += 2;
        if (gnt0 !== 1'b1) begin errors++; $display("FAIL mid_rr_gnt0: got %b expected 1", gnt0); end
        if (gnt1 !== 1'b0) begin errors++; $display("FAIL mid_rr_gnt1: got %b expected 0", gnt1); end
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        w_int0 = 32'd42;
        for (int k = 0; k < 18; k++) begin
            @(posedge clk); #1;
            w_req0 = (k < 17);
            @(negedge clk);
            checks += 2;
            if (w_cnt !== 4'(k)) begin errors++; $display("FAIL wrap_cnt after %0d grants: got %h expected %h", k, w_cnt, 4'(k)); end
            if (w_gnt0 !== (k < 17)) begin errors++; $display("FAIL wrap_gnt0 c%0d: got %b", k, w_gnt0); end
        end
        w_req0 = 1'b0;
    endtask

    task automatic test_random();
        bit held0 = 1'b0, held1 = 1'b0;
        bit e_g0, e_g1;
        do_reset();
        for (int k = 0; k < 404; k++) begin
            @(posedge clk); #1;
            if (k >= 400) begin
                req0 = 1'b0; req1 = 1'b0;
            end else begin
                if (!held0) begin req0 = ($urandom_range(0, 2) != 0); int0 = rnd_op(); end
                if (!held1) begin req1 = ($urandom_range(0, 2) != 0); int1 = rnd_op(); end
            end
            @(negedge clk);
            e_g0 = req0 && (!req1 || m_last);
            e_g1 = req1 && (!req0 || !m_last);
            held0 = req0 && !gnt0;
            held1 = req1 && !gnt1;
            checks += 6;
            if (gnt0 !== e_g0) begin errors++; $display("FAIL rnd_gnt0 c%0d: got %b expected %b", k, gnt0, e_g0); end
            if (gnt1 !== e_g1) begin errors++; $display("FAIL rnd_gnt1 c%0d: got %b expected %b", k, gnt1, e_g1); end
            if (fp_vld0 !== m_v0) begin errors++; $display("FAIL rnd_vld0 c%0d: got %b expected %b", k, fp_vld0, m_v0); end
            if (fp_vld1 !== m_v1) begin errors++; $display("FAIL rnd_vld1 c%0d: got %b expected %b", k, fp_vld1, m_v1); end
            if (fp_out !== m_hold) begin errors++; $display("FAIL rnd_fp c%0d: got %h expected %h", k, fp_out, m_hold); end
            if (grant_cnt !== m_cnt) begin errors++; $display("FAIL rnd_cnt c%0d: got %0d expected %0d", k, grant_cnt, m_cnt); end
        end
        checks++;
        if (m_q.size() > 1) begin errors++; $display("FAIL rnd_drain: got %0d pending expected <=1", m_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_boundary();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
